hack_ram_arbiter: RTL and testbench
===================================

# hack_ram_arbiter

Two-port arbiter that shares the single-port Hack data RAM (`single_port_ram`, 1-cycle registered read) between the CPU data port and a secondary DMA/debug requester such as a test loader or screen refresher. The CPU has priority. A starvation counter forces a DMA slot after a bounded wait, and `cpu_stall` freezes the CPU for that cycle. The block sits between `CPU`/DMA master and `single_port_ram`, and owns all RAM address, write and data muxing.

## Interface
- `AW`, 15, RAM address width (matches `addressM`)
- `DW`, 16, data width
- `STARVE_MAX`, 8, consecutive CPU-won cycles with DMA pending before DMA is forced (range 1..255)

- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  synchronous, active-high reset
- `cpu_en`  in  1  CPU wants RAM this cycle (read or write)
- `cpu_wr`  in  1  CPU write strobe (`writeM`)
- `cpu_addr`  in  AW  CPU address (`addressM`)
- `cpu_din`  in  DW  CPU write data (`outM`)
- `cpu_dout`  out  DW  CPU read data (`inM`)
- `cpu_stall`  out  1  CPU must hold its state this cycle
- `dma_req`  in  1  DMA request, held until granted
- `dma_wr`  in  1  DMA write strobe, qualified by `dma_gnt`
- `dma_addr`  in  AW  DMA address
- `dma_din`  in  DW  DMA write data
- `dma_gnt`  out  1  DMA access performed this cycle
- `dma_rvalid`  out  1  DMA read data valid (cycle after a granted read)
- `dma_rdata`  out  DW  DMA read data
- `ram_addr`  out  AW  to RAM `a_addr`
- `ram_wr`  out  1  to RAM `a_wr`
- `ram_din`  out  DW  to RAM `a_din`
- `ram_dout`  in  DW  from RAM `a_dout`
- `stat_dma_gnt`  out  16  DMA grant count (see Configuration)
- `stat_cpu_stall`  out  16  CPU stall-cycle count (see Configuration)

## Operation
- Exactly one owner per cycle: CPU or DMA. The grant decision is combinational from the current inputs and registered state.
- `dma_gnt` = `dma_req` & !`reset` & (!`cpu_en` | `starve_cnt` == `STARVE_MAX`). Otherwise the CPU owns the cycle.
- `cpu_stall` = `dma_gnt` & `cpu_en`.
- RAM mux: the owner's addr and din drive the RAM. `ram_wr` = owner's write strobe. Ungranted strobes never reach the RAM.
- `starve_cnt` (8-bit register):
  - Increments when `dma_req` is high and the CPU wins.
  - Clears when `dma_gnt` is high or `dma_req` is low.
  - Saturates at `STARVE_MAX`.
- `owner_q` register records the previous cycle's owner and access type, so that `ram_dout` is routed to the correct requester.
- CPU read path:
  - `cpu_dout` = `ram_dout` when `owner_q` = CPU.
  - Otherwise `cpu_dout` = `cpu_hold`, the last CPU-owned `ram_dout`, captured each cycle after a CPU cycle.
  - Result: a stalled CPU sees stable `inM`.
- DMA read path: `dma_rvalid` is asserted the cycle after a granted DMA read with `dma_wr`=0, with `dma_rdata` = `ram_dout`. A granted DMA write produces no `dma_rvalid`.
- The DMA master deasserts `dma_req` or changes address only after seeing `dma_gnt`. Back-to-back DMA grants are legal while `cpu_en`=0.

## Timing
- Grant and stall: same cycle as the request (0-cycle decision). RAM write commits at the end of the granted cycle.
- Read latency: 1 cycle for both ports (RAM registered read).
- Worst-case DMA wait with `cpu_en` stuck high: `STARVE_MAX` cycles, then one granted cycle. The CPU loses at most 1 cycle in every `STARVE_MAX`+1.
- Reset values:
  - `starve_cnt`=0, `owner_q`=CPU, `cpu_hold`=0.
  - `dma_rvalid`=0, `dma_rdata`=`ram_dout` passthrough.
  - Stats counters = 0.
- During reset: `dma_gnt`=0, `cpu_stall`=0, CPU owns the mux.
- Reset mid-DMA read: `dma_rvalid` is 0 in the following cycle. The DMA master re-requests.
- `STARVE_MAX` reached while `cpu_en`=0: DMA is granted normally and the counter clears.
- Simultaneous CPU and DMA write to the same address on a forced cycle: only the DMA write commits. The stalled CPU retries the write next cycle and wins.

## Configuration
- `HACK_ARB_STATS_EN` defined:
  - `stat_dma_gnt` increments on every `dma_gnt` cycle.
  - `stat_cpu_stall` increments on every `cpu_stall` cycle.
  - Both are 16-bit, saturate at 65535 and clear on reset.
- Undefined: both stat outputs are tied to 0 and the counter logic is omitted.

## Test plan
- CPU only (`dma_req`=0):
  - CPU writes 472 to addr 256, then reads 256.
  - Expect `cpu_dout`=472 one cycle after the read, `cpu_stall` never high, `dma_gnt` never high.
- DMA with CPU idle (`cpu_en`=0):
  - DMA writes 10 to addr 300, then reads 300.
  - Expect `dma_gnt`=1 in both cycles, `dma_rvalid`=1 with `dma_rdata`=10 in the cycle after the read.
- Starvation (`STARVE_MAX`=8, `cpu_en`=1 continuously, `dma_req` raised at cycle 0):
  - Expect `dma_gnt` and `cpu_stall` both high at cycle 8 only, and `starve_cnt` back to 0 at cycle 9.
- Stall hold:
  - CPU reads addr 401 (=21), then is stalled by a forced DMA read of addr 402 (=22).
  - Expect `cpu_dout` to stay 21 during the stall cycle and `dma_rdata`=22.
- Reset mid-operation:
  - Assert `reset` in the cycle after a DMA read grant.
  - Expect `dma_rvalid`=0, `starve_cnt`=0, stats=0 (with `HACK_ARB_STATS_EN`), and no RAM write during reset.
- Stats (`HACK_ARB_STATS_EN` defined):
  - 3 forced DMA grants under continuous `cpu_en`.
  - Expect `stat_dma_gnt`=3 and `stat_cpu_stall`=3. Both read 0 when the macro is undefined.

Source files
------------

// File: rtl/hack_ram_arbiter.sv
// hack_ram_arbiter: shares the Hack data RAM between the CPU (priority) and a DMA/debug port with starvation-forced DMA slots.
// Optional HACK_ARB_STATS_EN adds saturating grant/stall counters.
module hack_ram_arbiter #(
  parameter int AW = 15,
  parameter int DW = 16,
  parameter int STARVE_MAX = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_en,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  output logic [DW-1:0] cpu_dout,
  output logic          cpu_stall,
  input  logic          dma_req,
  input  logic          dma_wr,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_din,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_rdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_wr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic [15:0]   stat_dma_gnt,
  output logic [15:0]   stat_cpu_stall
);
  typedef enum logic [1:0] {OWN_CPU, OWN_DMA_RD, OWN_DMA_WR} owner_t;
  localparam logic [7:0] SMAX = 8'(STARVE_MAX);
  logic [7:0]    r_starve_cnt;
  owner_t        r_owner_q;
  logic [DW-1:0] r_cpu_hold;
  logic          w_dma_gnt;
  assign w_dma_gnt  = dma_req & ~reset & (~cpu_en | (r_starve_cnt == SMAX));
  assign dma_gnt    = w_dma_gnt;
  assign cpu_stall  = w_dma_gnt & cpu_en;
  assign ram_addr   = w_dma_gnt ? dma_addr : cpu_addr;
  assign ram_din    = w_dma_gnt ? dma_din : cpu_din;
  assign ram_wr     = ~reset & (w_dma_gnt ? dma_wr : cpu_en & cpu_wr);
  // A stalled CPU keeps seeing the last data it owned, not the DMA read.
  assign cpu_dout   = (r_owner_q == OWN_CPU) ? ram_dout : r_cpu_hold;
  assign dma_rvalid = ~reset & (r_owner_q == OWN_DMA_RD);
  assign dma_rdata  = ram_dout;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve_cnt <= '0;
      r_owner_q    <= OWN_CPU;
      r_cpu_hold   <= '0;
    end else begin
      r_starve_cnt <= (w_dma_gnt | ~dma_req) ? '0 : (r_starve_cnt == SMAX) ? r_starve_cnt : r_starve_cnt + 8'd1;
      r_owner_q    <= !w_dma_gnt ? OWN_CPU : dma_wr ? OWN_DMA_WR : OWN_DMA_RD;
      if (r_owner_q == OWN_CPU) r_cpu_hold <= ram_dout;
    end
  end
`ifdef HACK_ARB_STATS_EN
  logic [15:0] r_stat_gnt;
  logic [15:0] r_stat_stall;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_gnt   <= '0;
      r_stat_stall <= '0;
    end else begin
      r_stat_gnt   <= r_stat_gnt + {15'd0, w_dma_gnt & ~&r_stat_gnt};
      r_stat_stall <= r_stat_stall + {15'd0, w_dma_gnt & cpu_en & ~&r_stat_stall};
    end
  end
  assign stat_dma_gnt   = r_stat_gnt;
  assign stat_cpu_stall = r_stat_stall;
`else
  assign stat_dma_gnt   = '0;
  assign stat_cpu_stall = '0;
`endif
endmodule

// File: tb/tb_hack_ram_arbiter.sv
// tb_hack_ram_arbiter: table-driven and sequence checks of hack_ram_arbiter against a behavioural registered-read RAM.
module tb_hack_ram_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_en, cpu_wr, dma_req, dma_wr;
  logic [14:0] cpu_addr, dma_addr, ram_addr;
  logic [15:0] cpu_din, dma_din, cpu_dout, dma_rdata, ram_din, ram_dout;
  logic        cpu_stall, dma_gnt, dma_rvalid, ram_wr;
  logic [15:0] stat_dma_gnt, stat_cpu_stall;
  logic [15:0] mem [0:32767];
  int checks = 0, errors = 0;
  int n_gnt = 0, n_stall = 0;
  bit seen_rst = 0;

  typedef struct {
    int rst, ce, cw, ca, cd, dr, dw, da, dd;
    int eg, es, erv, ewr, ecd, erd, erdin;
  } vec_t;

  hack_ram_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_en(cpu_en), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_din(dma_din),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_din(ram_din), .ram_dout(ram_dout),
    .stat_dma_gnt(stat_dma_gnt), .stat_cpu_stall(stat_cpu_stall)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wr) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  function automatic vec_t mk(int rst, int ce, int cw, int ca, int cd, int dr, int dw, int da, int dd,
                              int eg, int es, int erv, int ewr, int ecd, int erd, int erdin);
    vec_t v;
    v = '{rst, ce, cw, ca, cd, dr, dw, da, dd, eg, es, erv, ewr, ecd, erd, erdin};
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input vec_t v);
    @(negedge clk);
    reset    = (v.rst != 0);
    cpu_en   = (v.ce != 0);
    cpu_wr   = (v.cw != 0);
    cpu_addr = 15'(v.ca);
    cpu_din  = 16'(v.cd);
    dma_req  = (v.dr != 0);
    dma_wr   = (v.dw != 0);
    dma_addr = 15'(v.da);
    dma_din  = 16'(v.dd);
    #1;
    chk("dma_gnt", int'(dma_gnt), v.eg);
    chk("cpu_stall", int'(cpu_stall), v.es);
    chk("dma_rvalid", int'(dma_rvalid), v.erv);
    chk("ram_wr", int'(ram_wr), v.ewr);
    if (v.ecd >= 0) chk("cpu_dout", int'(cpu_dout), v.ecd);
    if (v.erd >= 0) chk("dma_rdata", int'(dma_rdata), v.erd);
    if (v.erdin >= 0) chk("ram_din", int'(ram_din), v.erdin);
    if (seen_rst) begin
`ifdef HACK_ARB_STATS_EN
      chk("stat_dma_gnt", int'(stat_dma_gnt), n_gnt);
      chk("stat_cpu_stall", int'(stat_cpu_stall), n_stall);
`else
      chk("stat_dma_gnt", int'(stat_dma_gnt), 0);
      chk("stat_cpu_stall", int'(stat_cpu_stall), 0);
`endif
    end
    if (v.rst != 0) begin
      n_gnt = 0;
      n_stall = 0;
      seen_rst = 1;
    end else begin
      n_gnt += v.eg;
      n_stall += v.es;
    end
  endtask

  initial begin
    vec_t tbl [11];
    // reset, CPU write/read of 256, DMA write/read of 300, DMA preload of 401/402
    tbl[0]  = mk(1, 1,1,  7, 55, 1,1,  7, 66, 0,0,0,0,  -1, -1, 55);
    tbl[1]  = mk(1, 1,1,  7, 55, 1,1,  7, 66, 0,0,0,0,  -1, -1, 55);
    tbl[2]  = mk(0, 0,0,  0,  0, 0,0,  0,  0, 0,0,0,0,  -1, -1, -1);
    tbl[3]  = mk(0, 1,1,256,472, 0,0,  0,  0, 0,0,0,1,  -1, -1, 472);
    tbl[4]  = mk(0, 1,0,256,  0, 0,0,  0,  0, 0,0,0,0,  -1, -1, -1);
    tbl[5]  = mk(0, 0,0,256,  0, 0,0,  0,  0, 0,0,0,0, 472, -1, -1);
    tbl[6]  = mk(0, 0,0,256,  0, 1,1,300, 10, 1,0,0,1, 472, -1, 10);
    tbl[7]  = mk(0, 0,0,256,  0, 1,0,300,  0, 1,0,0,0, 472, -1, -1);
    tbl[8]  = mk(0, 0,0,256,  0, 0,0,  0,  0, 0,0,1,0, 472, 10, -1);
    tbl[9]  = mk(0, 0,0,256,  0, 1,1,401, 21, 1,0,0,1, 472, -1, 21);
    tbl[10] = mk(0, 0,0,256,  0, 1,1,402, 22, 1,0,0,1, 472, -1, 22);
    for (int i = 0; i < 11; i++) step(tbl[i]);
    // starvation with CPU reading 401: forced grants at 8 and 17, held cpu_dout during the stall
    for (int k = 0; k < 19; k++)
      step(mk(0, 1,0,401,0, int'(k != 18),0, (k <= 8) ? 402 : 401, 0,
              int'(k == 8 || k == 17), int'(k == 8 || k == 17), int'(k == 9 || k == 18), 0,
              (k == 0) ? 472 : 21, (k == 9) ? 22 : (k == 18) ? 21 : -1, -1));
    // reset the cycle after a DMA read grant; no writes may leak during reset
    step(mk(0, 0,0,401, 0, 1,0,402, 0, 1,0,0,0, 21, -1, -1));
    step(mk(1, 1,1,401,77, 1,1,402,88, 0,0,0,0, 21, -1, 77));
    step(mk(0, 0,0,401, 0, 0,0,  0, 0, 0,0,0,0, 21, -1, -1));
    chk("mem401_after_reset", int'(mem[401]), 21);
    // build up a partial starvation count, then reset must clear it
    for (int k = 0; k < 5; k++) step(mk(0, 1,0,401,0, 1,0,402,0, 0,0,0,0, 21, -1, -1));
    step(mk(1, 1,0,401,0, 1,0,402,0, 0,0,0,0, 21, -1, -1));
    // three forced DMA writes colliding with CPU writes to 500
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 9; k++)
        step(mk(0, 1,1,500,7, 1,1,500,9, int'(k == 8), int'(k == 8), 0, 1, -1, -1, (k == 8) ? 9 : 7));
    step(mk(0, 1,1,500,7, 0,0,0,0, 0,0,0,1, -1, -1, 7));
    step(mk(0, 0,0,500,0, 0,0,0,0, 0,0,0,0, -1, -1, -1));
    chk("mem500_cpu_retry", int'(mem[500]), 7);
`ifdef HACK_ARB_STATS_EN
    chk("stat_dma_gnt_final", int'(stat_dma_gnt), 3);
    chk("stat_cpu_stall_final", int'(stat_cpu_stall), 3);
`else
    chk("stat_dma_gnt_final", int'(stat_dma_gnt), 0);
    chk("stat_cpu_stall_final", int'(stat_cpu_stall), 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
